// File: rtl/gray_ptr_sync.sv
// Multi-stage synchronizer for Gray-coded FIFO pointers, with registered binary output and change pulse.
// Define GRAY_PTR_SYNC_ERR_EN to build the Gray-violation monitor (ERR_PULSE / saturating ERR_CNT).
module gray_ptr_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] ASYNC_GRAY,
    input  logic             ERR_CLR,
    output logic [WIDTH-1:0] SYNC_GRAY,
    output logic [WIDTH-1:0] SYNC_BIN,
    output logic             CHG_PULSE,
    output logic             ERR_PULSE,
    output logic [CNT_W-1:0] ERR_CNT
);

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when more than one bit is set: clearing the lowest set bit leaves something behind.
    function automatic logic multi_bit(input logic [WIDTH-1:0] v);
        return |(v & (v - WIDTH'(1)));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] bin_q;
    logic             chg_q;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] bin_d;
    logic             chg_d;

    // Synchronizer chain: pure flop-to-flop, nothing in between.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], ASYNC_GRAY};
        end
    end

    assign SYNC_GRAY = sync_q[STAGES-1];
    assign diff      = sync_q[STAGES-1] ^ prev_q;
    assign bin_d     = gray2bin(sync_q[STAGES-1]);
    assign chg_d     = |diff;

    // Post-synchronizer stage: binary conversion and change detect, aligned to each other.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prev_q <= '0;
            bin_q  <= '0;
            chg_q  <= 1'b0;
        end else begin
            prev_q <= sync_q[STAGES-1];
            bin_q  <= bin_d;
            chg_q  <= chg_d;
        end
    end

    assign SYNC_BIN  = bin_q;
    assign CHG_PULSE = chg_q;

`ifdef GRAY_PTR_SYNC_ERR_EN
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority; a violation coinciding with the clear is dropped.
    always_comb begin
        cnt_d = cnt_q;
        if (ERR_CLR) begin
            cnt_d = '0;
        end else if (multi_bit(diff)) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= multi_bit(diff);
            cnt_q <= cnt_d;
        end
    end

    assign ERR_PULSE = err_q;
    assign ERR_CNT   = cnt_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = ERR_CLR;
    assign ERR_PULSE      = 1'b0;
    assign ERR_CNT        = '0;
`endif

endmodule

// File: doc/gray_ptr_sync.md
Name: gray_ptr_sync

Overview:
- Parametrised multi-bit synchronizer for Gray-coded FIFO pointers crossing into the CLK domain.
- Extends a plain per-bit flop chain in four ways: configurable depth, registered Gray-to-binary conversion, a change-detect pulse, and a Gray-coding violation monitor with a saturating error counter.
- Sits on the read side (write pointer) and the write side (read pointer) of the async FIFO, one instance per direction.

Parameters:
- WIDTH, 4, pointer width in bits including the wrap bit (address bits + 1); minimum 2.
- STAGES, 2, synchronizer flop depth per bit; minimum 2.
- CNT_W, 8, width of the violation counter.

Ports:
- CLK  in  1  destination-domain clock
- RST  in  1  reset, asynchronous, active-low
- ASYNC_GRAY  in  WIDTH  Gray pointer from the source domain; asynchronous to CLK
- ERR_CLR  in  1  synchronous clear of ERR_CNT, CLK domain
- SYNC_GRAY  out  WIDTH  synchronized Gray pointer
- SYNC_BIN  out  WIDTH  registered binary equivalent of SYNC_GRAY
- CHG_PULSE  out  1  one-cycle pulse when the synchronized pointer changes
- ERR_PULSE  out  1  one-cycle pulse on a Gray violation (more than one bit changed)
- ERR_CNT  out  CNT_W  saturating count of violations

Behaviour:
- Reset (RST low, asynchronous):
  - All stage flops, prev register, SYNC_BIN, CHG_PULSE, ERR_PULSE and ERR_CNT go to 0.
  - SYNC_GRAY = 0 while reset is held.
  - Reset mid-operation clears everything immediately. After release, no pulse is generated until the chain output differs from 0.
- Chain:
  - s[0] <= ASYNC_GRAY; s[k] <= s[k-1] for k = 1..STAGES-1.
  - SYNC_GRAY = s[STAGES-1], taken directly from the flop output with no added logic.
  - Latency: ASYNC_GRAY change to SYNC_GRAY is STAGES rising edges.
  - No logic between stage flops. Stage flops must be identifiable for synthesis attributes.
- prev register: prev <= s[STAGES-1] every cycle. Define d = s[STAGES-1] XOR prev (combinational).
- Binary conversion:
  - SYNC_BIN <= gray2bin(s[STAGES-1]), where bin[WIDTH-1] = g[WIDTH-1] and bin[i] = bin[i+1] XOR g[i].
  - SYNC_BIN lags SYNC_GRAY by exactly 1 cycle. Total latency is STAGES+1.
- Change detect:
  - CHG_PULSE <= OR-reduce(d).
  - Asserts in the same cycle SYNC_BIN first shows the new value, for exactly 1 cycle per change.
  - Back-to-back changes on consecutive cycles give CHG_PULSE high on consecutive cycles.
- Violation monitor:
  - ERR_PULSE <= (popcount(d) > 1). It is registered, aligned with CHG_PULSE, and also raises CHG_PULSE.
  - ERR_CNT behaviour, in priority order:
    - ERR_CLR = 1: ERR_CNT <= 0. Clear wins over a simultaneous violation, and that violation is not counted.
    - Else, popcount(d) > 1 and ERR_CNT < 2^CNT_W-1: increment by 1.
    - At 2^CNT_W-1: hold (saturate, no wrap).
- Wrap-around: the Gray transition from MSB-only (e.g. 1000 for WIDTH=4) to 0000 is a single-bit change. SYNC_BIN goes 15 -> 0 with no error.
- Data integrity: no output depends combinationally on ASYNC_GRAY.

Optional Feature:
- Macro: GRAY_PTR_SYNC_ERR_EN
- Defined: the violation monitor is built as described above.
- Undefined:
  - popcount logic and ERR_CNT register are not instantiated.
  - ERR_PULSE is tied to 0 and ERR_CNT to all zeros.
  - ERR_CLR is ignored.
  - Chain, SYNC_BIN and CHG_PULSE behaviour are unchanged.

Test Plan:
- Reset with ASYNC_GRAY=0000, hold 10 cycles, release -> all outputs 0, no CHG_PULSE or ERR_PULSE.
- WIDTH=4, STAGES=2; ASYNC_GRAY 0000 -> 0001 one cycle after reset release -> SYNC_GRAY=0001 after 2 edges, SYNC_BIN=0001 and CHG_PULSE=1 after 3 edges, CHG_PULSE=0 at edge 4.
- Gray counter stepped every 3 CLK cycles through all 16 codes and wraps 1000 -> 0000 -> SYNC_BIN follows 0..15, 0; 16 CHG_PULSEs; ERR_CNT stays 0.
- With macro defined, CNT_W=2: inject 0000 -> 0011 (two-bit jump) -> ERR_PULSE and CHG_PULSE one cycle, ERR_CNT=1. Four more injections -> ERR_CNT saturates at 3. ERR_CLR asserted on the same cycle as a violation -> ERR_CNT=0.
- STAGES=3: single-bit change -> SYNC_GRAY latency 3 edges, SYNC_BIN latency 4. Assert RST mid-pipeline -> outputs 0 immediately, no pulse after release with input 0.
- Macro undefined: repeat the two-bit jump -> SYNC_BIN updates, CHG_PULSE pulses, ERR_PULSE=0, ERR_CNT=0.
